ex_div_ctrl: RTL and testbench
==============================

# ex_div_ctrl

Division issue/retire controller in the EX stage: it sits directly upstream of the iterative divider. It detects DIV/DIVU in EX, latches the operands, runs the divider's start/annul handshake and holds the pipeline stalled until the quotient and remainder return. It then hands HI/LO write data to the EX output path in the same cycle the stall releases.

## Interface
Parameters: none. Opcodes and widths come from the shared defines.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- aluop_i  in  8  EX opcode. EXE_DIV_OP=8'b00011010, EXE_DIVU_OP=8'b00011011.
- reg1_i  in  32  dividend from EX.
- reg2_i  in  32  divisor from EX.
- flush_i  in  1  pipeline flush; cancels any division in flight.
- stallreq_o  out  1  stall request to the pipeline controller.
- div_opdata1_o  out  32  latched dividend to the divider.
- div_opdata2_o  out  32  latched divisor to the divider.
- div_signed_o  out  1  latched signed flag (1 = DIV).
- div_start_o  out  1  divider start; held high while busy.
- div_annul_o  out  1  divider cancel.
- div_result_i  in  64  {remainder, quotient} from the divider.
- div_ready_i  in  1  divider result valid.
- whilo_o  out  1  HI/LO write enable for this instruction.
- hi_o  out  32  HI write data (remainder).
- lo_o  out  32  LO write data (quotient).
- div_zero_o  out  1  divide-by-zero flag. Tied 0 unless the macro below is defined.

## Operation
- Decode: is_div = (aluop_i == EXE_DIV_OP) or (aluop_i == EXE_DIVU_OP).
- FSM states, two-bit encoding: IDLE, BUSY, DRAIN.
- **IDLE**
  - div_start_o = 0.
  - stallreq_o = is_div & ~flush_i.
  - On is_div & ~flush_i, at the clock edge: latch reg1_i, reg2_i and (aluop_i == EXE_DIV_OP) into the operand registers, then go to BUSY.
- **BUSY**
  - div_start_o = ~flush_i.
  - stallreq_o = ~div_ready_i.
  - flush_i has priority: div_annul_o = 1, no writeback, go to DRAIN.
  - Otherwise, on div_ready_i: whilo_o = 1, hi_o = div_result_i[63:32], lo_o = div_result_i[31:0], go to DRAIN. These outputs are combinational in this cycle, so they advance with the instruction into EX/MEM.
- **DRAIN**
  - Exactly one cycle; div_start_o = 0 so the divider returns to its free state.
  - stallreq_o = is_div. A following division waits here and is latched later from IDLE.
  - Always go to IDLE.
- Operand registers are stable from BUSY entry until IDLE. The divider re-reads operand sign bits at completion, so these registers must not change during that window.
- whilo_o, hi_o, lo_o and div_annul_o are 0 whenever not explicitly driven above.
- Reset, including mid-BUSY: state = IDLE, operand and signed registers = 0. All outputs then evaluate to 0 in the next cycle. The divider shares rst and resets together with this block.

## Timing
- Start-to-ready latency is set by the divider, nominally 35 cycles from BUSY entry. This block assumes no fixed latency and waits for div_ready_i.
- Stall runs from the cycle the division is first seen in IDLE through the BUSY cycle before div_ready_i. It deasserts in the ready cycle.
- Back-to-back divisions: one mandatory DRAIN cycle with div_start_o low between them, and a second division sees stallreq_o high during that cycle.
- A flush in the same cycle as div_ready_i discards the result: whilo_o = 0.

## Configuration
- DIV_ZERO_TRAP_EN defined:
  - In IDLE, is_div & ~flush_i & reg2_i == 0 asserts div_zero_o for one cycle, combinationally.
  - No stall, no start, whilo_o = 0; the FSM stays in IDLE.
- DIV_ZERO_TRAP_EN undefined:
  - div_zero_o = 0.
  - Zero divisors go to the divider like any other operand, and the zero result it returns is written back through whilo_o.

## Structure
- The shared defines package holds EXE_DIV_OP, EXE_DIVU_OP, RstEnable, ZeroWord, DivStart/DivStop and the DIVC_IDLE/BUSY/DRAIN state encodings.
- Single module, FSM inline, no sub-module. The divider is instantiated beside this block in the EX wrapper, not inside it.

## Test plan
- DIVU 100/7: stall held until ready; then whilo_o = 1 for exactly one cycle with hi_o = 2, lo_o = 14; next cycle is DRAIN, with start low.
- DIV 0xFFFFFFF9/2 (−7/2): lo_o = 0xFFFFFFFD, hi_o = 0xFFFFFFFF; div_signed_o = 1 throughout BUSY.
- Two DIVs back-to-back: the second is stalled through DRAIN with div_start_o = 0, re-latched in IDLE, and both write back correct values.
- flush_i five cycles into BUSY: div_annul_o = 1 that cycle, whilo_o never asserts, FSM passes DRAIN → IDLE, and a following DIVU 9/3 gives lo_o = 3, hi_o = 0.
- DIV 5/0: with DIV_ZERO_TRAP_EN, div_zero_o pulses and stallreq_o = 0. Without it, the divider runs and whilo_o writes hi_o = lo_o = 0.
- rst asserted mid-BUSY: next cycle stallreq_o, div_start_o and whilo_o are 0 and the FSM is in IDLE.

Source files
------------

// File: rtl/ex_div_ctrl_pkg.sv
// rtl/ex_div_ctrl_pkg.sv - shared opcodes, constants and state encodings for the EX-stage divide controller
package ex_div_ctrl_pkg;

  localparam logic [7:0]  EXE_DIV_OP  = 8'b00011010;
  localparam logic [7:0]  EXE_DIVU_OP = 8'b00011011;
  localparam logic [7:0]  EXE_NOP_OP  = 8'b00000000;

  localparam logic        RstEnable   = 1'b1;
  localparam logic [31:0] ZeroWord    = 32'h0000_0000;
  localparam logic        DivStart    = 1'b1;
  localparam logic        DivStop     = 1'b0;

  typedef enum logic [1:0] {
    DIVC_IDLE  = 2'b00,
    DIVC_BUSY  = 2'b01,
    DIVC_DRAIN = 2'b10
  } divc_state_t;

  function automatic logic is_div_op(input logic [7:0] op);
    return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
  endfunction

endpackage

// File: rtl/ex_div_ctrl.sv
// rtl/ex_div_ctrl.sv - DIV/DIVU issue/retire controller beside the iterative divider
// Optional divide-by-zero trap selected by DIV_ZERO_TRAP_EN.
module ex_div_ctrl
  import ex_div_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic        flush_i,
  output logic        stallreq_o,
  output logic [31:0] div_opdata1_o,
  output logic [31:0] div_opdata2_o,
  output logic        div_signed_o,
  output logic        div_start_o,
  output logic        div_annul_o,
  input  logic [63:0] div_result_i,
  input  logic        div_ready_i,
  output logic        whilo_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        div_zero_o
);

  divc_state_t r_state;
  divc_state_t w_next_state;
  logic [31:0] r_opdata1;
  logic [31:0] r_opdata2;
  logic        r_signed;

  logic        w_is_div;
  logic        w_div_zero;
  logic        w_latch;

  assign w_is_div = is_div_op(aluop_i);

`ifdef DIV_ZERO_TRAP_EN
  // A zero divisor is trapped in IDLE and never reaches the divider.
  assign w_div_zero = (r_state == DIVC_IDLE) & w_is_div & ~flush_i & (reg2_i == ZeroWord);
`else
  assign w_div_zero = 1'b0;
`endif

  assign w_latch    = (r_state == DIVC_IDLE) & w_is_div & ~flush_i & ~w_div_zero;
  assign div_zero_o = w_div_zero;

  // Operands only load from IDLE, so they hold steady through BUSY and DRAIN
  // while the divider may still re-read the sign bits.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      r_state   <= DIVC_IDLE;
      r_opdata1 <= ZeroWord;
      r_opdata2 <= ZeroWord;
      r_signed  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_latch) begin
        r_opdata1 <= reg1_i;
        r_opdata2 <= reg2_i;
        r_signed  <= (aluop_i == EXE_DIV_OP);
      end
    end
  end

  assign div_opdata1_o = r_opdata1;
  assign div_opdata2_o = r_opdata2;
  assign div_signed_o  = r_signed;

  always_comb begin
    w_next_state = r_state;
    stallreq_o   = 1'b0;
    div_start_o  = DivStop;
    div_annul_o  = 1'b0;
    whilo_o      = 1'b0;
    hi_o         = ZeroWord;
    lo_o         = ZeroWord;
    case (r_state)
      DIVC_IDLE: begin
        stallreq_o = w_latch;
        if (w_latch) begin
          w_next_state = DIVC_BUSY;
        end
      end
      DIVC_BUSY: begin
        div_start_o = flush_i ? DivStop : DivStart;
        stallreq_o  = ~div_ready_i;
        if (flush_i) begin
          div_annul_o  = 1'b1;
          w_next_state = DIVC_DRAIN;
        end else if (div_ready_i) begin
          // Combinational writeback so the result travels with the instruction into EX/MEM.
          whilo_o      = 1'b1;
          hi_o         = div_result_i[63:32];
          lo_o         = div_result_i[31:0];
          w_next_state = DIVC_DRAIN;
        end
      end
      DIVC_DRAIN: begin
        stallreq_o   = w_is_div;
        w_next_state = DIVC_IDLE;
      end
      default: begin
        w_next_state = DIVC_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ex_div_ctrl.sv
// tb/tb_ex_div_ctrl.sv - self-checking bench for ex_div_ctrl with a behavioural divider model
// Honours DIV_ZERO_TRAP_EN when defined.
module tb_ex_div_ctrl;
  import ex_div_ctrl_pkg::*;

  logic        clk;
  logic        rst;
  logic [7:0]  aluop;
  logic [31:0] reg1;
  logic [31:0] reg2;
  logic        flush;
  logic        stallreq;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        dsigned;
  logic        dstart;
  logic        dannul;
  logic [63:0] dresult;
  logic        dready;
  logic        whilo;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        dzero;

  int n_pass;
  int n_total;

`ifdef DIV_ZERO_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  ex_div_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .aluop_i      (aluop),
    .reg1_i       (reg1),
    .reg2_i       (reg2),
    .flush_i      (flush),
    .stallreq_o   (stallreq),
    .div_opdata1_o(opdata1),
    .div_opdata2_o(opdata2),
    .div_signed_o (dsigned),
    .div_start_o  (dstart),
    .div_annul_o  (dannul),
    .div_result_i (dresult),
    .div_ready_i  (dready),
    .whilo_o      (whilo),
    .hi_o         (hi),
    .lo_o         (lo),
    .div_zero_o   (dzero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [7:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    int          flush_at;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  // Arithmetic reference: {remainder, quotient}, truncating toward zero; a zero divisor yields zero.
  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'h0) return 64'h0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'h0, a});
      sb = longint'({32'h0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One division from its first IDLE cycle through DRAIN; the bench plays the divider.
  task automatic run_div(input vec_t v, input logic [7:0] next_op);
    logic done, rdy, fl, wb;
    aluop = v.op; reg1 = v.a; reg2 = v.b; flush = 1'b0; dready = 1'b0; dresult = 64'h0;
    #2;
    if (TRAP && v.b == 32'h0) begin
      chk("trap_zero", dzero, 1'b1);
      chk("trap_stall", stallreq, 1'b0);
      chk("trap_start", dstart, 1'b0);
      chk("trap_whilo", whilo, 1'b0);
      cyc();
      aluop = next_op;
      return;
    end
    chk("idle_stall", stallreq, 1'b1);
    chk("idle_start", dstart, 1'b0);
    chk("idle_zero", dzero, 1'b0);
    cyc();
    done = 1'b0;
    for (int k = 1; !done; k++) begin
      rdy = (k == v.lat);
      fl  = (k == v.flush_at);
      wb  = rdy && !fl;
      dready = rdy;
      flush  = fl;
      dresult = rdy ? ref_div(dsigned, opdata1, opdata2) : {$urandom, $urandom};
      #2;
      chk("busy_stall", stallreq, !rdy);
      chk("busy_start", dstart, !fl);
      chk("busy_annul", dannul, fl);
      chk("busy_whilo", whilo, wb);
      chk("busy_hi", hi, wb ? v.hi : 32'h0);
      chk("busy_lo", lo, wb ? v.lo : 32'h0);
      chk("busy_op1", opdata1, v.a);
      chk("busy_op2", opdata2, v.b);
      chk("busy_signed", dsigned, v.op == EXE_DIV_OP);
      cyc();
      if (rdy || fl) done = 1'b1;
      if (k > 200) begin
        chk("busy_bound", 1'b0, 1'b1);
        done = 1'b1;
      end
    end
    aluop = next_op; dready = 1'b0; flush = 1'b0; reg1 = $urandom; reg2 = $urandom;
    #2;
    chk("drain_start", dstart, 1'b0);
    chk("drain_stall", stallreq, is_div_op(next_op));
    chk("drain_whilo", whilo, 1'b0);
    chk("drain_op1", opdata1, v.a);
    cyc();
  endtask

  vec_t vecs[7];
  vec_t rv;

  initial begin
    n_pass = 0; n_total = 0;
    rst = 1'b1; aluop = EXE_NOP_OP; reg1 = 0; reg2 = 0; flush = 0; dresult = 0; dready = 0;

    vecs[0] = '{EXE_DIVU_OP, 32'd100,        32'd7,          35, -1, 32'd2,        32'd14};
    vecs[1] = '{EXE_DIV_OP,  32'hFFFF_FFF9,  32'd2,          35, -1, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[2] = '{EXE_DIV_OP,  32'd5,          32'd0,          35, -1, 32'd0,        32'd0};
    vecs[3] = '{EXE_DIVU_OP, 32'd1000,       32'd10,         35,  5, 32'd0,        32'd0};
    vecs[4] = '{EXE_DIVU_OP, 32'd9,          32'd3,          35, -1, 32'd0,        32'd3};
    vecs[5] = '{EXE_DIV_OP,  32'd20,         32'hFFFF_FFFD,   3,  3, 32'd0,        32'd0};
    vecs[6] = '{EXE_DIVU_OP, 32'hFFFF_FFFF,  32'd1,           1, -1, 32'd0,        32'hFFFF_FFFF};

    cyc(); cyc();
    rst = 1'b0;
    #2;
    chk("rst_stall", stallreq, 1'b0);
    chk("rst_start", dstart, 1'b0);
    chk("rst_whilo", whilo, 1'b0);
    chk("rst_op1", opdata1, 32'h0);
    chk("rst_op2", opdata2, 32'h0);
    chk("rst_signed", dsigned, 1'b0);
    chk("rst_zero", dzero, 1'b0);
    cyc();

    for (int i = 0; i < 7; i++)
      run_div(vecs[i], (i < 6) ? vecs[i+1].op : EXE_NOP_OP);

    aluop = EXE_NOP_OP;
    #2;
    chk("idle_nop_stall", stallreq, 1'b0);
    cyc();

    // A division flushed while still in IDLE must not stall or launch.
    aluop = EXE_DIV_OP; reg1 = 32'd40; reg2 = 32'd4; flush = 1'b1;
    #2;
    chk("idleflush_stall", stallreq, 1'b0);
    cyc();
    aluop = EXE_NOP_OP; flush = 1'b0;
    #2;
    chk("idleflush_start", dstart, 1'b0);
    chk("idleflush_stall2", stallreq, 1'b0);
    cyc();

    // Reset in the middle of BUSY.
    aluop = EXE_DIVU_OP; reg1 = 32'd50; reg2 = 32'd5;
    cyc();
    repeat (4) cyc();
    #2;
    chk("pre_rst_start", dstart, 1'b1);
    rst = 1'b1;
    cyc();
    rst = 1'b0; aluop = EXE_NOP_OP;
    #2;
    chk("midrst_stall", stallreq, 1'b0);
    chk("midrst_start", dstart, 1'b0);
    chk("midrst_whilo", whilo, 1'b0);
    chk("midrst_op1", opdata1, 32'h0);
    chk("midrst_signed", dsigned, 1'b0);
    cyc();
    run_div(vecs[4], EXE_NOP_OP);

    for (int i = 0; i < 24; i++) begin
      logic [63:0] e;
      rv.op = $urandom_range(0, 1) ? EXE_DIV_OP : EXE_DIVU_OP;
      rv.a  = $urandom;
      case ($urandom_range(0, 3))
        0: rv.b = 32'h0;
        1: rv.b = $urandom_range(1, 17);
        2: rv.b = -$urandom_range(1, 17);
        default: rv.b = $urandom;
      endcase
      rv.lat = $urandom_range(1, 40);
      rv.flush_at = ($urandom_range(0, 5) == 0) ? $urandom_range(1, rv.lat) : -1;
      e = ref_div(rv.op == EXE_DIV_OP, rv.a, rv.b);
      rv.hi = e[63:32];
      rv.lo = e[31:0];
      run_div(rv, $urandom_range(0, 1) ? EXE_DIVU_OP : EXE_NOP_OP);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
